// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master with slave-select hold for back-to-back transfers
module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int SS_SETUP = 8,
  parameter int GAP      = 16
) (
  input  logic       ext_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] send_data,
  input  logic       hold_ss,
  output logic       ready,
  output logic [7:0] recv_data,
  output logic       recv_ready,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD
  } state_t;

  // Terminal counts: each phase lasts N cycles, counted 0..N-1.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SS_SETUP - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  recv_data_q, recv_data_d;
  logic        recv_ready_q, recv_ready_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic        ready_q, ready_d;
  logic        miso_meta_q, miso_sync_q;
  logic        accept;

  // Next-state and registered-output logic; every output is derived from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    recv_data_d  = recv_data_q;
    recv_ready_d = 1'b0;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    accept       = start & ready_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        if (accept) begin
          state_d    = ST_SETUP;
          cnt_d      = 8'd0;
          bit_cnt_d  = 4'd0;
          tx_shift_d = send_data;
          mosi_d     = send_data[7];
        end
      end

      ST_HOLD: begin
        sclk_d = 1'b0;
        // A new byte wins over releasing the slave.
        if (accept) begin
          state_d    = ST_SETUP;
          cnt_d      = 8'd0;
          bit_cnt_d  = 4'd0;
          tx_shift_d = send_data;
          mosi_d     = send_data[7];
        end else if (!hold_ss) begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        sclk_d = 1'b0;
        mosi_d = tx_shift_q[7];
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 8'd0;
          if (sclk_q) begin
            // Falling edge: capture the bit held during the high phase, present the next one.
            sclk_d     = 1'b0;
            rx_shift_d = {rx_shift_q[6:0], miso_sync_q};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q != 4'd7) begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              mosi_d     = tx_shift_q[6];
            end
          end else if (bit_cnt_q == 4'd8) begin
            // Last low half-period is complete: hand the byte over.
            state_d      = ST_GAP;
            recv_data_d  = rx_shift_q;
            recv_ready_d = 1'b1;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_GAP: begin
        sclk_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = hold_ss ? ST_HOLD : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
      end
    endcase

    ss_d    = (state_d == ST_IDLE);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      bit_cnt_q    <= 4'd0;
      tx_shift_q   <= 8'd0;
      rx_shift_q   <= 8'd0;
      recv_data_q  <= 8'd0;
      recv_ready_q <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      ss_q         <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      recv_data_q  <= recv_data_d;
      recv_ready_q <= recv_ready_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      ss_q         <= ss_d;
      ready_q      <= ready_d;
    end
  end

  // Two-flop synchronizer for the slave's data line.
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign ready      = ready_q;
  assign recv_data  = recv_data_q;
  assign recv_ready = recv_ready_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign ss         = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master against a timeline model
`timescale 1ns/1ps
module tb_spi_master;

  localparam int D      = 8;
  localparam int S      = 8;
  localparam int G      = 16;
  localparam int T_RECV = S + 16 * D;
  localparam int T_END  = T_RECV + G;
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_BUSY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold_ss = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       ready, recv_ready, sclk, mosi, ss, miso;
  logic [7:0] recv_data;

  logic [7:0] slave_byte = 8'h00;
  logic [2:0] sl_idx = 3'd0;

  logic       lb_start = 1'b0;
  logic [7:0] lb_send = 8'h00;
  logic       lb_ready, lb_recv_ready, lb_sclk, lb_mosi, lb_ss;
  logic [7:0] lb_recv_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  spi_master u_dut (
    .ext_clk(clk), .rst(rst), .start(start), .send_data(send_data), .hold_ss(hold_ss),
    .ready(ready), .recv_data(recv_data), .recv_ready(recv_ready), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ss(ss)
  );

  spi_master #(.CLK_DIV(4)) u_lb (
    .ext_clk(clk), .rst(rst), .start(lb_start), .send_data(lb_send), .hold_ss(1'b0),
    .ready(lb_ready), .recv_data(lb_recv_data), .recv_ready(lb_recv_ready), .sclk(lb_sclk),
    .mosi(lb_mosi), .miso(lb_mosi), .ss(lb_ss)
  );

  // Mode-0 slave: presents the next bit after each falling sclk, rewinds on ss high.
  always @(negedge sclk or posedge ss) begin
    if (ss) sl_idx <= 3'd0;
    else    sl_idx <= sl_idx + 3'd1;
  end
  assign miso = slave_byte[3'd7 - sl_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer model: tracks accept time and derives every output from elapsed cycles.
  int         m_mode = M_IDLE;
  int         m_a = 0;
  logic       m_ready = 1'b0;
  logic       m_in_rst = 1'b1;
  logic       m_started = 1'b0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_recv = 8'h00;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_started = 1'b1;
    m_in_rst = rst;
    if (rst) begin
      m_mode  = M_IDLE;
      m_ready = 1'b0;
      m_recv  = 8'h00;
    end else begin
      if (m_mode != M_BUSY && m_ready && start) begin
        m_mode  = M_BUSY;
        m_a     = cyc;
        m_tx    = send_data;
        m_rx    = slave_byte;
        m_ready = 1'b0;
      end else if (m_mode == M_HOLD && !hold_ss) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_BUSY && cyc - m_a == T_RECV) begin
        m_recv = m_rx;
      end else if (m_mode == M_BUSY && cyc - m_a == T_END) begin
        m_mode = hold_ss ? M_HOLD : M_IDLE;
      end
      if (m_mode != M_BUSY) m_ready = 1'b1;
    end
  end

  // Compare the DUT with the model on every falling clock edge.
  always @(negedge clk) begin
    int   r;
    int   k;
    logic e_sclk;
    if (m_started) begin
      r = cyc - m_a;
      if (m_in_rst) begin
        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", ready, 0);
        chk("rst_recv_ready", recv_ready, 0);
        chk("rst_recv_data", recv_data, 8'h00);
      end else begin
        chk("recv_data", recv_data, m_recv);
        chk("ready", ready, m_ready);
        if (m_mode == M_BUSY) begin
          e_sclk = (r >= S) && (r < T_RECV) && (((r - S) / D) % 2 == 0);
          k = (r < S + D) ? 0 : ((r - S - D) / (2 * D) + 1);
          if (k > 7) k = 7;
          chk("ss_busy", ss, 0);
          chk("sclk", sclk, e_sclk);
          chk("mosi", mosi, m_tx[7 - k]);
          chk("recv_ready", recv_ready, (r == T_RECV));
        end else begin
          chk("ss_rest", ss, (m_mode == M_IDLE));
          chk("sclk_rest", sclk, 0);
          chk("recv_ready_rest", recv_ready, 0);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] tx);
    send_data = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input int max);
    int i;
    i = 0;
    while (!ready && i < max) begin
      @(negedge clk);
      i++;
    end
    if (!ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic watch(input int max, output int pulses, output logic ss_hi,
                       output logic [7:0] bits, output int nrise, output int done_cyc);
    logic prev;
    int   i;
    pulses = 0; ss_hi = 1'b0; bits = 8'h00; nrise = 0; prev = sclk; i = 0;
    while (i < max) begin
      @(negedge clk);
      i++;
      if (recv_ready) pulses++;
      if (ss) ss_hi = 1'b1;
      if (sclk && !prev) begin
        bits = {bits[6:0], mosi};
        nrise++;
      end
      prev = sclk;
      if (ready) break;
    end
    done_cyc = cyc;
    if (!ready) chk("watch_timeout", 0, 1);
  endtask

  task automatic lb_xfer(input logic [7:0] b);
    int i;
    int t0;
    i = 0;
    while (!lb_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!lb_ready) chk("lb_ready_timeout", 0, 1);
    lb_send = b;
    lb_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    lb_start = 1'b0;
    i = 0;
    while (!lb_recv_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("lb_pulse", lb_recv_ready, 1);
    chk("lb_data", lb_recv_data, b);
    chk("lb_latency", cyc - t0, 73);
    chk("lb_ss", lb_ss, 0);
    chk("lb_sclk", lb_sclk, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pulses;
    int         nrise;
    int         done_cyc;
    int         t0;
    int         nr;
    int         i;
    logic       ss_hi;
    logic       prev;
    logic [7:0] bits;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ss", ss, 1);
    chk("reset_ready", ready, 0);
    chk("reset_recv_data", recv_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);

    // Single byte A5 out, 3C back.
    hold_ss = 1'b0;
    slave_byte = 8'h3C;
    t0 = cyc;
    do_start(8'hA5);
    chk("ss_fall_next_cycle", ss, 0);
    watch(400, pulses, ss_hi, bits, nrise, done_cyc);
    chk("t1_mosi_bits", bits, 8'hA5);
    chk("t1_rises", nrise, 8);
    chk("t1_recv", recv_data, 8'h3C);
    chk("t1_pulses", pulses, 1);
    chk("t1_ss_high", ss, 1);
    chk("t1_ss_low_through_return", done_cyc - t0, 153);

    // Back-to-back with ss held: 01 then FF.
    hold_ss = 1'b1;
    slave_byte = 8'h96;
    do_start(8'h01);
    watch(400, pulses, ss_hi, bits, nrise, done_cyc);
    chk("t2a_mosi_bits", bits, 8'h01);
    chk("t2a_recv", recv_data, 8'h96);
    chk("t2a_pulses", pulses, 1);
    chk("t2a_ss_never_high", ss_hi, 0);
    chk("t2a_hold_ss_low", ss, 0);
    slave_byte = 8'h69;
    do_start(8'hFF);
    chk("t2b_setup_ss", ss, 0);
    chk("t2b_setup_ready", ready, 0);
    watch(400, pulses, ss_hi, bits, nrise, done_cyc);
    chk("t2b_mosi_bits", bits, 8'hFF);
    chk("t2b_recv", recv_data, 8'h69);
    chk("t2b_pulses", pulses, 1);
    chk("t2b_ss_never_high", ss_hi, 0);

    // Leaving HOLD without a start releases ss on the next cycle.
    hold_ss = 1'b0;
    @(negedge clk);
    chk("hold_exit_ss", ss, 1);
    chk("hold_exit_ready", ready, 1);

    // Start held high all through the byte, with send_data and hold_ss wiggling.
    wait_ready(50);
    slave_byte = 8'hE7;
    do_start(8'h3C);
    fork
      begin
        start = 1'b1;
        send_data = 8'hFF;
        hold_ss = 1'b1;
        repeat (110) @(negedge clk);
        start = 1'b0;
        hold_ss = 1'b0;
      end
      watch(400, pulses, ss_hi, bits, nrise, done_cyc);
    join
    chk("t3_mosi_bits", bits, 8'h3C);
    chk("t3_rises", nrise, 8);
    chk("t3_pulses", pulses, 1);
    chk("t3_recv", recv_data, 8'hE7);
    chk("t3_ss_idle", ss, 1);

    // Reset after the 4th rising sclk.
    wait_ready(50);
    slave_byte = 8'hA5;
    do_start(8'hC3);
    nr = 0; prev = sclk; i = 0; pulses = 0;
    while (nr < 4 && i < 200) begin
      @(negedge clk);
      i++;
      if (recv_ready) pulses++;
      if (sclk && !prev) nr++;
      prev = sclk;
    end
    chk("t4_reached_rise4", nr, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_ss", ss, 1);
    chk("t4_sclk", sclk, 0);
    chk("t4_recv_ready", recv_ready, 0);
    chk("t4_recv_data", recv_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ready_after", ready, 1);
    chk("t4_no_pulse", pulses, 0);
    slave_byte = 8'h81;
    do_start(8'h5A);
    watch(400, pulses, ss_hi, bits, nrise, done_cyc);
    chk("t4_mosi_bits", bits, 8'h5A);
    chk("t4_recv", recv_data, 8'h81);
    chk("t4_pulses", pulses, 1);

    // Loopback at CLK_DIV=4.
    lb_xfer(8'h00);
    lb_xfer(8'h80);
    lb_xfer(8'h7F);
    lb_xfer(8'hFF);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
